// File: rtl/dbu_ctrl.sv
// Debug-unit controller: gates the CPU run enable for continuous or single-step
// execution, drives the memory/register browse pointer and selects the display word.
module dbu_ctrl #(
   parameter int STATUS_W     = 247,
   parameter int WIDTH        = 32,
   parameter int IRW_BIT      = 239,
   parameter int MAX_STEP_CYC = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                succ,
   input  logic                step,
   input  logic                inc,
   input  logic                dec,
   input  logic                m_rf,
   input  logic [2:0]          sel,
   input  logic [STATUS_W-1:0] status,
   input  logic [WIDTH-1:0]    m_data,
   input  logic [WIDTH-1:0]    rf_data,
   output logic                run,
   output logic [7:0]          m_rf_addr,
   output logic [WIDTH-1:0]    disp,
   output logic [15:0]         led,
   output logic                step_busy,
   output logic                step_err
);

   localparam int CNT_W  = $clog2(MAX_STEP_CYC) + 1;
   localparam int SGN_LO = 7 * WIDTH;

   typedef enum logic [1:0] {IDLE, STEP_FIRST, STEP_RUN} state_t;

   // Synchronizer bit order: {m_rf, dec, inc, step, succ}; the third stage
   // only covers the bits that need edge or change detection.
   logic [4:0] sync1_reg, sync2_reg;
   logic [4:1] sync3_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
         sync3_reg <= '0;
      end else begin
         sync1_reg <= {m_rf, dec, inc, step, succ};
         sync2_reg <= sync1_reg;
         sync3_reg <= sync2_reg[4:1];
      end
   end

   logic succ_s, m_rf_s, step_pulse, inc_pulse, dec_pulse, m_rf_chg, ir_write;
   assign succ_s     = sync2_reg[0];
   assign m_rf_s     = sync2_reg[4];
   assign step_pulse = sync2_reg[1] & ~sync3_reg[1];
   assign inc_pulse  = sync2_reg[2] & ~sync3_reg[2];
   assign dec_pulse  = sync2_reg[3] & ~sync3_reg[3];
   assign m_rf_chg   = sync2_reg[4] ^ sync3_reg[4];
   assign ir_write   = status[IRW_BIT];

   // Step sequencer
   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             err_reg, err_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      err_next   = err_reg;
      if (succ_s) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (step_pulse) begin
                  state_next = STEP_FIRST;
                  cnt_next   = '0;
                  err_next   = 1'b0;
               end
            end
            STEP_FIRST: begin
               // The fetch at which the step started is executed even though
               // ir_write is already high here.
               state_next = STEP_RUN;
               cnt_next   = cnt_reg + 1'b1;
            end
            STEP_RUN: begin
               if (ir_write) begin
                  state_next = IDLE;
               end else if (cnt_reg == CNT_W'(MAX_STEP_CYC - 1)) begin
                  state_next = IDLE;
                  err_next   = 1'b1;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign run       = succ_s | (state_reg == STEP_FIRST) | ((state_reg == STEP_RUN) & ~ir_write);
   assign step_busy = (state_reg != IDLE);
   assign step_err  = err_reg;

   // Browse pointer; register mode wraps within 32 entries.
   logic [7:0] addr_reg, addr_next;
   logic [4:0] reg_inc, reg_dec;
   assign reg_inc = addr_reg[4:0] + 5'd1;
   assign reg_dec = addr_reg[4:0] - 5'd1;

   always_comb begin
      addr_next = addr_reg;
      if (m_rf_chg) begin
         addr_next = '0;
      end else if ((sel == 3'd0) && (inc_pulse ^ dec_pulse)) begin
         if (m_rf_s)
            addr_next = inc_pulse ? addr_reg + 8'd1 : addr_reg - 8'd1;
         else
            addr_next = {3'b000, inc_pulse ? reg_inc : reg_dec};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) addr_reg <= '0;
      else     addr_reg <= addr_next;
   end

   assign m_rf_addr = addr_reg;

   // field[0] = next_PC ... field[6] = mdr
   logic [WIDTH-1:0] field [0:6];
   generate
      for (genvar gi = 0; gi < 7; gi++) begin : g_field
         assign field[gi] = status[WIDTH*(7-gi)-1 -: WIDTH];
      end
   endgenerate

   always_comb begin
      disp = field[0];
      case (sel)
         3'd0:    disp = m_rf_s ? m_data : rf_data;
         3'd1:    disp = field[0];
         3'd2:    disp = field[1];
         3'd3:    disp = field[2];
         3'd4:    disp = field[3];
         3'd5:    disp = field[4];
         3'd6:    disp = field[5];
         default: disp = field[6];
      endcase
   end

   assign led = (sel == 3'd0) ? {7'b0, m_rf_s, addr_reg} : status[SGN_LO+15:SGN_LO];

   logic unused_sgn_hi;
   assign unused_sgn_hi = ^status[STATUS_W-1:SGN_LO+16];

endmodule

// File: tb/tb_dbu_ctrl.sv
// Directed bench for dbu_ctrl with a 4-cycle multicycle CPU model driving status.
module tb_dbu_ctrl;

   logic          clk, rst, succ, step, inc, dec, m_rf;
   logic [2:0]    sel;
   logic [246:0]  status;
   logic [31:0]   m_data, rf_data;
   logic          run, step_busy, step_err;
   logic [7:0]    m_rf_addr;
   logic [31:0]   disp;
   logic [15:0]   led;

   int tests = 0;
   int fails = 0;
   int run_cnt = 0;

   // CPU model: fetch (ir_write) on phase 0, PC advances on each executed fetch
   logic [1:0]  phase = 2'd0;
   logic [31:0] pc = 32'h0000_0010;
   logic        stuck = 1'b0;
   logic        irw;
   logic [31:0] next_pc, instr, opa, opb, alu, mdr;

   assign irw    = stuck ? 1'b0 : (phase == 2'd0);
   assign status = {7'h55, irw, 15'h1234, next_pc, pc, instr, opa, opb, alu, mdr};

   dbu_ctrl #(.STATUS_W(247), .WIDTH(32), .IRW_BIT(239), .MAX_STEP_CYC(16)) dut (
      .clk(clk), .rst(rst), .succ(succ), .step(step), .inc(inc), .dec(dec),
      .m_rf(m_rf), .sel(sel), .status(status), .m_data(m_data), .rf_data(rf_data),
      .run(run), .m_rf_addr(m_rf_addr), .disp(disp), .led(led),
      .step_busy(step_busy), .step_err(step_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (run) begin
         phase <= phase + 2'd1;
         if (phase == 2'd0) pc <= pc + 32'd4;
      end
   end

   always @(negedge clk) if (run) run_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: 0x%08h", tag, got);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_step(input string tag);
      int seen = 0;
      run_cnt = 0;
      step = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (i == 2) step = 1'b0;
         if (step_busy) seen = 1;
         else if (seen != 0) break;
      end
      step = 1'b0;
      check({tag, "_done"}, {31'b0, (seen != 0) && !step_busy}, 32'd1);
      wait_cyc(3);
   endtask

   task automatic press(input logic i, input logic d);
      inc = i;
      dec = d;
      wait_cyc(4);
      inc = 1'b0;
      dec = 1'b0;
      wait_cyc(4);
   endtask

   logic [31:0] pc0;
   logic [31:0] exp_f [8];

   initial begin
      rst = 1'b1; succ = 1'b0; step = 1'b0; inc = 1'b0; dec = 1'b0; m_rf = 1'b0; sel = 3'd0;
      m_data = 32'h1111_1111; rf_data = 32'h2222_2222;
      next_pc = 32'h0000_0014; instr = 32'h0040_0093; opa = 32'hA5A5_0001;
      opb = 32'h0000_5A5A; alu = 32'h1234_5678; mdr = 32'hDEAD_BEEF;

      wait_cyc(3);
      check("rst_run",  {31'b0, run}, 32'd0);
      check("rst_addr", {24'b0, m_rf_addr}, 32'd0);
      check("rst_busy", {31'b0, step_busy}, 32'd0);
      check("rst_err",  {31'b0, step_err}, 32'd0);
      check("rst_led",  {16'b0, led}, 32'd0);
      rst = 1'b0;
      wait_cyc(2);

      // Normal step from a fetch boundary
      pc0 = pc;
      do_step("step1");
      check("step1_runcnt", run_cnt, 32'd4);
      check("step1_busy",   {31'b0, step_busy}, 32'd0);
      check("step1_err",    {31'b0, step_err}, 32'd0);
      check("step1_pc",     pc, pc0 + 32'd4);

      // ir_write stuck low: timeout after MAX_STEP_CYC run cycles
      stuck = 1'b1;
      do_step("tmo");
      check("tmo_runcnt", run_cnt, 32'd16);
      check("tmo_err",    {31'b0, step_err}, 32'd1);
      stuck = 1'b0;
      do_step("step2");
      check("step2_runcnt", run_cnt, 32'd4);
      check("step2_err",    {31'b0, step_err}, 32'd0);

      // Continuous-mode latency
      succ = 1'b1;
      @(negedge clk); check("succ_rise1", {31'b0, run}, 32'd0);
      @(negedge clk); check("succ_rise2", {31'b0, run}, 32'd1);
      succ = 1'b0;
      @(negedge clk); check("succ_fall1", {31'b0, run}, 32'd1);
      @(negedge clk); check("succ_fall2", {31'b0, run}, 32'd0);
      wait_cyc(2);

      // Browse pointer wrap, memory mode
      m_rf = 1'b1;
      wait_cyc(5);
      check("mem_start", {24'b0, m_rf_addr}, 32'h00);
      press(1'b0, 1'b1);
      check("mem_dec_wrap", {24'b0, m_rf_addr}, 32'hFF);
      press(1'b1, 1'b0);
      check("mem_inc_wrap", {24'b0, m_rf_addr}, 32'h00);

      // Register mode
      m_rf = 1'b0;
      wait_cyc(5);
      press(1'b0, 1'b1);
      check("reg_dec_wrap", {24'b0, m_rf_addr}, 32'h1F);
      press(1'b1, 1'b1);
      check("inc_dec_same", {24'b0, m_rf_addr}, 32'h1F);
      check("led_sel0",     {16'b0, led}, 32'h001F);
      sel = 3'd3;
      press(1'b1, 1'b0);
      check("inc_sel_nz",   {24'b0, m_rf_addr}, 32'h1F);
      sel = 3'd0;

      // m_rf toggle clears the pointer
      m_rf = 1'b1;
      wait_cyc(5);
      for (int k = 0; k < 42; k++) press(1'b1, 1'b0);
      check("mem_2a", {24'b0, m_rf_addr}, 32'h2A);
      m_rf = 1'b0;
      wait_cyc(5);
      check("mrf_toggle_clr", {24'b0, m_rf_addr}, 32'h00);

      // Reset mid-step drops run after the reset edge
      step = 1'b1;
      wait_cyc(4);
      step = 1'b0;
      check("mid_rst_pre", {31'b0, run}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_run",  {31'b0, run}, 32'd0);
      check("mid_rst_busy", {31'b0, step_busy}, 32'd0);
      rst = 1'b0;
      wait_cyc(3);

      // succ abort mid-step
      step = 1'b1;
      wait_cyc(4);
      step = 1'b0;
      check("abort_pre_busy", {31'b0, step_busy}, 32'd1);
      succ = 1'b1;
      wait_cyc(3);
      check("abort_run",  {31'b0, run}, 32'd1);
      check("abort_busy", {31'b0, step_busy}, 32'd0);
      check("abort_err",  {31'b0, step_err}, 32'd0);
      succ = 1'b0;
      wait_cyc(4);

      // Display select sweep
      exp_f[0] = rf_data; exp_f[1] = next_pc; exp_f[2] = pc;  exp_f[3] = instr;
      exp_f[4] = opa;     exp_f[5] = opb;     exp_f[6] = alu; exp_f[7] = mdr;
      for (int s = 0; s < 8; s++) begin
         sel = 3'(s);
         @(negedge clk);
         check($sformatf("disp_sel%0d", s), disp, exp_f[s]);
         if (s != 0) check($sformatf("led_sel%0d", s), {16'b0, led}, {16'b0, irw, 15'h1234});
      end
      sel = 3'd0;
      m_rf = 1'b1;
      wait_cyc(3);
      check("disp_mem", disp, 32'h1111_1111);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
